tag_pair_alloc: RTL and testbench

Two-table tag allocator feeding the tag-distinctness checker stage. Maintains table A and table B, each 8 entries of {valid, 16-bit tag}. Accepts insert and release requests per table and guarantees that no tag is ever simultaneously valid in both tables. Drives the `vlda/vldb/taga/tagb` buses consumed directly by the downstream checker.

---
 rtl/tag_pair_alloc_if.sv | 49 ++++
 rtl/tag_pair_alloc.sv | 112 +++++++++++
 tb/tb_tag_pair_alloc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tag_pair_alloc_if.sv
// Request/response bundle between the tag allocator and its requester/downstream checker.
// Valid/ready style: each *_vld request is sampled on a rising edge and answered by exactly one ack or nack pulse the next cycle.
interface tag_pair_alloc_if #(
   parameter int DEPTH = 8,
   parameter int TW    = 16
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic                       ins_a_vld;
   logic [TW-1:0]              ins_a_tag;
   logic                       ins_b_vld;
   logic [TW-1:0]              ins_b_tag;
   logic                       rel_a_vld;
   logic [IW-1:0]              rel_a_idx;
   logic                       rel_b_vld;
   logic [IW-1:0]              rel_b_idx;
   logic                       flush;

   logic                       ins_a_ack;
   logic                       ins_b_ack;
   logic                       ins_a_nack;
   logic                       ins_b_nack;
   logic [IW-1:0]              ins_a_idx;
   logic [IW-1:0]              ins_b_idx;
   logic [DEPTH-1:0]           vlda;
   logic [DEPTH-1:0]           vldb;
   logic [DEPTH-1:0][TW-1:0]   taga;
   logic [DEPTH-1:0][TW-1:0]   tagb;
   logic                       full_a;
   logic                       full_b;
   logic                       rel_err;
   logic [CW-1:0]              count_a;
   logic [CW-1:0]              count_b;

   modport master (
      output ins_a_vld, ins_a_tag, ins_b_vld, ins_b_tag,
             rel_a_vld, rel_a_idx, rel_b_vld, rel_b_idx, flush,
      input  ins_a_ack, ins_b_ack, ins_a_nack, ins_b_nack, ins_a_idx, ins_b_idx,
             vlda, vldb, taga, tagb, full_a, full_b, rel_err, count_a, count_b
   );

   modport slave (
      input  ins_a_vld, ins_a_tag, ins_b_vld, ins_b_tag,
             rel_a_vld, rel_a_idx, rel_b_vld, rel_b_idx, flush,
      output ins_a_ack, ins_b_ack, ins_a_nack, ins_b_nack, ins_a_idx, ins_b_idx,
             vlda, vldb, taga, tagb, full_a, full_b, rel_err, count_a, count_b
   );
endinterface

// File: rtl/tag_pair_alloc.sv
// Two-table tag allocator: no tag is ever valid in both table A and table B at once.
// All decisions use registered state only; A wins a same-cycle tag tie against B.
module tag_pair_alloc #(
   parameter int DEPTH = 8,
   parameter int TW    = 16
) (
   input  logic               clk,
   input  logic               rstn,
   tag_pair_alloc_if.slave    bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic             hit_a, hit_b;
   logic [IW-1:0]    free_a, free_b;
   logic             acc_a, acc_b;
   logic             rel_a_ok, rel_b_ok, rel_bad;
   logic [DEPTH-1:0] vld_a_n, vld_b_n;
   logic [CW-1:0]    count_a_n, count_b_n;

   always_comb begin
      hit_a  = 1'b0;
      hit_b  = 1'b0;
      free_a = '0;
      free_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.vlda[i] && bus.taga[i] == bus.ins_a_tag) hit_a = 1'b1;
         if (bus.vldb[i] && bus.tagb[i] == bus.ins_a_tag) hit_a = 1'b1;
         if (bus.vlda[i] && bus.taga[i] == bus.ins_b_tag) hit_b = 1'b1;
         if (bus.vldb[i] && bus.tagb[i] == bus.ins_b_tag) hit_b = 1'b1;
      end
      // Descending scan leaves the lowest-index free slot selected.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!bus.vlda[i]) free_a = IW'(i);
         if (!bus.vldb[i]) free_b = IW'(i);
      end

      acc_a = bus.ins_a_vld && !bus.flush && !bus.full_a && !hit_a;
      acc_b = bus.ins_b_vld && !bus.flush && !bus.full_b && !hit_b &&
              !(acc_a && bus.ins_a_tag == bus.ins_b_tag);

      rel_a_ok = bus.rel_a_vld && !bus.flush && bus.vlda[bus.rel_a_idx];
      rel_b_ok = bus.rel_b_vld && !bus.flush && bus.vldb[bus.rel_b_idx];
      rel_bad  = !bus.flush &&
                 ((bus.rel_a_vld && !bus.vlda[bus.rel_a_idx]) ||
                  (bus.rel_b_vld && !bus.vldb[bus.rel_b_idx]));

      // A release targets a valid slot and an insert a free one, so they never collide.
      vld_a_n   = bus.vlda;
      vld_b_n   = bus.vldb;
      count_a_n = bus.count_a;
      count_b_n = bus.count_b;
      if (rel_a_ok) begin
         vld_a_n[bus.rel_a_idx] = 1'b0;
         count_a_n              = count_a_n - CW'(1);
      end
      if (acc_a) begin
         vld_a_n[free_a] = 1'b1;
         count_a_n       = count_a_n + CW'(1);
      end
      if (rel_b_ok) begin
         vld_b_n[bus.rel_b_idx] = 1'b0;
         count_b_n              = count_b_n - CW'(1);
      end
      if (acc_b) begin
         vld_b_n[free_b] = 1'b1;
         count_b_n       = count_b_n + CW'(1);
      end
      if (bus.flush) begin
         vld_a_n   = '0;
         vld_b_n   = '0;
         count_a_n = '0;
         count_b_n = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.vlda       <= '0;
         bus.vldb       <= '0;
         bus.taga       <= '0;
         bus.tagb       <= '0;
         bus.count_a    <= '0;
         bus.count_b    <= '0;
         bus.full_a     <= 1'b0;
         bus.full_b     <= 1'b0;
         bus.ins_a_ack  <= 1'b0;
         bus.ins_b_ack  <= 1'b0;
         bus.ins_a_nack <= 1'b0;
         bus.ins_b_nack <= 1'b0;
         bus.ins_a_idx  <= '0;
         bus.ins_b_idx  <= '0;
         bus.rel_err    <= 1'b0;
      end else begin
         bus.vlda    <= vld_a_n;
         bus.vldb    <= vld_b_n;
         bus.count_a <= count_a_n;
         bus.count_b <= count_b_n;
         bus.full_a  <= (count_a_n == CW'(DEPTH));
         bus.full_b  <= (count_b_n == CW'(DEPTH));
         if (acc_a) bus.taga[free_a] <= bus.ins_a_tag;
         if (acc_b) bus.tagb[free_b] <= bus.ins_b_tag;
         bus.ins_a_ack  <= acc_a;
         bus.ins_b_ack  <= acc_b;
         bus.ins_a_nack <= bus.ins_a_vld && !acc_a;
         bus.ins_b_nack <= bus.ins_b_vld && !acc_b;
         bus.ins_a_idx  <= acc_a ? free_a : '0;
         bus.ins_b_idx  <= acc_b ? free_b : '0;
         bus.rel_err    <= bus.rel_err || rel_bad;
      end
   end
endmodule

// File: tb/tb_tag_pair_alloc.sv
// Directed bench for tag_pair_alloc: a vector table walked cycle by cycle, then
// hand sequences for asynchronous reset and table-B fill / same-cycle insert+release.
module tb_tag_pair_alloc;
   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_bad;

   tag_pair_alloc_if #(.DEPTH(8), .TW(16)) bus();

   tag_pair_alloc #(.DEPTH(8), .TW(16)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iav;  logic [15:0] iat;
      logic        ibv;  logic [15:0] ibt;
      logic        rav;  logic [2:0]  rai;
      logic        rbv;  logic [2:0]  rbi;
      logic        fl;
      logic        a_ack; logic a_nack; logic [2:0] a_idx;
      logic        b_ack; logic b_nack; logic [2:0] b_idx;
      logic [7:0]  vlda; logic [7:0] vldb;
      logic        fa; logic fb; logic err;
      logic        chk; logic [2:0] ti; logic [15:0] ta; logic [15:0] tb;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.ins_a_vld = 1'b0; bus.ins_a_tag = '0;
      bus.ins_b_vld = 1'b0; bus.ins_b_tag = '0;
      bus.rel_a_vld = 1'b0; bus.rel_a_idx = '0;
      bus.rel_b_vld = 1'b0; bus.rel_b_idx = '0;
      bus.flush     = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   // No tag may be valid in both tables at once; checked every cycle out of reset.
   always @(negedge clk) begin
      if (rstn) begin
         logic ok;
         ok = 1'b1;
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               if (bus.vlda[i] && bus.vldb[j] && bus.taga[i] == bus.tagb[j]) ok = 1'b0;
         check("cross_table_distinct", {31'd0, ok}, 32'd1);
      end
   end

   initial begin
      vec_t v;
      n_cmp = 0;
      n_bad = 0;
      rstn  = 1'b0;
      idle_inputs();

      // Columns: iav iat ibv ibt rav rai rbv rbi fl | a_ack a_nack a_idx | b_ack b_nack b_idx |
      //          vlda vldb full_a full_b rel_err | chk idx taga[idx] tagb[idx]
      tbl.push_back('{1,16'h1234,0,16'h0,0,0,0,0,0, 1,0,0, 0,0,0, 8'h01,8'h00,0,0,0, 1,0,16'h1234,16'h0000});
      tbl.push_back('{0,16'h0,1,16'h1234,0,0,0,0,0, 0,0,0, 0,1,0, 8'h01,8'h00,0,0,0, 0,0,16'h0,16'h0});
      tbl.push_back('{1,16'h00AA,1,16'h00AA,0,0,0,0,0, 1,0,1, 0,1,0, 8'h03,8'h00,0,0,0, 1,1,16'h00AA,16'h0000});
      tbl.push_back('{0,16'h0,1,16'h0055,0,0,0,0,0, 0,0,0, 1,0,0, 8'h03,8'h01,0,0,0, 1,0,16'h1234,16'h0055});
      tbl.push_back('{1,16'h0055,0,16'h0,0,0,0,0,0, 0,1,0, 0,0,0, 8'h03,8'h01,0,0,0, 0,0,16'h0,16'h0});
      tbl.push_back('{0,16'h0,0,16'h0,1,0,1,0,0, 0,0,0, 0,0,0, 8'h02,8'h00,0,0,0, 1,0,16'h1234,16'h0055});
      tbl.push_back('{1,16'h0055,1,16'h1234,0,0,0,0,0, 1,0,0, 1,0,0, 8'h03,8'h01,0,0,0, 1,0,16'h0055,16'h1234});
      tbl.push_back('{1,16'h0077,0,16'h0,0,0,1,6,1, 0,1,0, 0,0,0, 8'h00,8'h00,0,0,0, 0,0,16'h0,16'h0});
      for (int k = 0; k < 8; k++) begin
         logic [8:0] one;
         one = 9'd1;
         v = '{1,16'h0010 + 16'(k),0,16'h0,0,0,0,0,0, 1,0,3'(k), 0,0,0,
               8'((one << (k + 1)) - 9'd1),8'h00,(k == 7),0,0,
               1,3'(k),16'h0010 + 16'(k),(k == 0) ? 16'h1234 : 16'h0000};
         tbl.push_back(v);
      end
      tbl.push_back('{1,16'h0018,0,16'h0,0,0,0,0,0, 0,1,0, 0,0,0, 8'hFF,8'h00,1,0,0, 0,0,16'h0,16'h0});
      tbl.push_back('{1,16'h0020,0,16'h0,1,3,0,0,0, 0,1,0, 0,0,0, 8'hF7,8'h00,0,0,0, 1,3,16'h0013,16'h0000});
      tbl.push_back('{1,16'h0020,0,16'h0,0,0,0,0,0, 1,0,3, 0,0,0, 8'hFF,8'h00,1,0,0, 1,3,16'h0020,16'h0000});
      tbl.push_back('{0,16'h0,1,16'h0020,0,0,0,0,0, 0,0,0, 0,1,0, 8'hFF,8'h00,1,0,0, 0,0,16'h0,16'h0});
      tbl.push_back('{0,16'h0,0,16'h0,0,0,1,5,0, 0,0,0, 0,0,0, 8'hFF,8'h00,1,0,1, 0,0,16'h0,16'h0});
      tbl.push_back('{0,16'h0,0,16'h0,0,0,0,0,0, 0,0,0, 0,0,0, 8'hFF,8'h00,1,0,1, 0,0,16'h0,16'h0});

      #2;
      check("reset_vlda", 32'(bus.vlda), 32'h0);
      check("reset_ack_nack", {28'd0, bus.ins_a_ack, bus.ins_a_nack, bus.ins_b_ack, bus.ins_b_nack}, 32'h0);
      check("reset_full_err", {29'd0, bus.full_a, bus.full_b, bus.rel_err}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      for (int k = 0; k < tbl.size(); k++) begin
         v = tbl[k];
         bus.ins_a_vld = v.iav; bus.ins_a_tag = v.iat;
         bus.ins_b_vld = v.ibv; bus.ins_b_tag = v.ibt;
         bus.rel_a_vld = v.rav; bus.rel_a_idx = v.rai;
         bus.rel_b_vld = v.rbv; bus.rel_b_idx = v.rbi;
         bus.flush     = v.fl;
         step();
         check($sformatf("v%0d_a_ack", k),  32'(bus.ins_a_ack),  32'(v.a_ack));
         check($sformatf("v%0d_a_nack", k), 32'(bus.ins_a_nack), 32'(v.a_nack));
         if (v.a_ack) check($sformatf("v%0d_a_idx", k), 32'(bus.ins_a_idx), 32'(v.a_idx));
         check($sformatf("v%0d_b_ack", k),  32'(bus.ins_b_ack),  32'(v.b_ack));
         check($sformatf("v%0d_b_nack", k), 32'(bus.ins_b_nack), 32'(v.b_nack));
         if (v.b_ack) check($sformatf("v%0d_b_idx", k), 32'(bus.ins_b_idx), 32'(v.b_idx));
         check($sformatf("v%0d_vlda", k),    32'(bus.vlda),    32'(v.vlda));
         check($sformatf("v%0d_vldb", k),    32'(bus.vldb),    32'(v.vldb));
         check($sformatf("v%0d_full_a", k),  32'(bus.full_a),  32'(v.fa));
         check($sformatf("v%0d_full_b", k),  32'(bus.full_b),  32'(v.fb));
         check($sformatf("v%0d_rel_err", k), 32'(bus.rel_err), 32'(v.err));
         check($sformatf("v%0d_count_a", k), 32'(bus.count_a), 32'($countones(v.vlda)));
         check($sformatf("v%0d_count_b", k), 32'(bus.count_b), 32'($countones(v.vldb)));
         if (v.chk) begin
            check($sformatf("v%0d_taga", k), 32'(bus.taga[v.ti]), 32'(v.ta));
            check($sformatf("v%0d_tagb", k), 32'(bus.tagb[v.ti]), 32'(v.tb));
         end
      end

      // Asynchronous reset mid-cycle: outputs clear well before the next edge.
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("async_vlda", 32'(bus.vlda), 32'h0);
      check("async_taga3", 32'(bus.taga[3]), 32'h0);
      check("async_tagb0", 32'(bus.tagb[0]), 32'h0);
      check("async_full_a", 32'(bus.full_a), 32'h0);
      check("async_rel_err", 32'(bus.rel_err), 32'h0);
      check("async_count_a", 32'(bus.count_a), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // Fill B, free one slot, then insert and release B in the same cycle.
      for (int i = 0; i < 8; i++) begin
         bus.ins_b_vld = 1'b1;
         bus.ins_b_tag = 16'h0100 + 16'(i);
         step();
         check($sformatf("fillb%0d_ack", i), 32'(bus.ins_b_ack), 32'h1);
         check($sformatf("fillb%0d_idx", i), 32'(bus.ins_b_idx), 32'(i));
      end
      check("fillb_full_b", 32'(bus.full_b), 32'h1);
      check("fillb_vldb", 32'(bus.vldb), 32'hFF);
      check("fillb_count_b", 32'(bus.count_b), 32'd8);

      bus.rel_b_vld = 1'b1; bus.rel_b_idx = 3'd0;
      step();
      check("relb0_vldb", 32'(bus.vldb), 32'hFE);
      check("relb0_full_b", 32'(bus.full_b), 32'h0);

      bus.rel_b_vld = 1'b1; bus.rel_b_idx = 3'd1;
      bus.ins_b_vld = 1'b1; bus.ins_b_tag = 16'h0200;
      step();
      check("insrel_ack", 32'(bus.ins_b_ack), 32'h1);
      check("insrel_idx", 32'(bus.ins_b_idx), 32'h0);
      check("insrel_vldb", 32'(bus.vldb), 32'hFD);
      check("insrel_tagb0", 32'(bus.tagb[0]), 32'h0200);
      check("insrel_tagb1_kept", 32'(bus.tagb[1]), 32'h0101);
      check("insrel_count_b", 32'(bus.count_b), 32'd7);
      check("insrel_rel_err", 32'(bus.rel_err), 32'h0);

      // A tag held in B must be refused by A.
      bus.ins_a_vld = 1'b1; bus.ins_a_tag = 16'h0105;
      step();
      check("a_vs_b_nack", 32'(bus.ins_a_nack), 32'h1);
      check("a_vs_b_vlda", 32'(bus.vlda), 32'h0);

      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
